// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch datapath: clock rate, derived defaults and
// the state encoding used by the pulse stretcher.
package stopwatch_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    // Stretcher defaults: 0.5 s high, 0.25 s minimum low gap, 7 queued pulses
    localparam int unsigned STRETCH_HIGH_DEFAULT  = CLK_HZ / 2;
    localparam int unsigned STRETCH_LOW_DEFAULT   = CLK_HZ / 4;
    localparam int unsigned STRETCH_DEPTH_DEFAULT = 7;

    // Stretcher state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter. Simultaneous inc and dec cancel; the count never
// wraps below zero or above MAX_VAL.
module sat_updown_cnt #(
    parameter int unsigned MAX_VAL = 7,
    parameter int unsigned WIDTH   = $clog2(MAX_VAL + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_max_o,
    output logic             at_zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign at_max_o  = (count_q == WIDTH'(MAX_VAL));
    assign at_zero_o = (count_q == '0);
    assign count_o   = count_q;

    // Next count: step once in the requested direction unless at the limit
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !at_max_o) begin
            count_d = count_q + WIDTH'(1);
        end else if (dec_i && !inc_i && !at_zero_o) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle request pulses into fixed-width level pulses with a
// guaranteed low gap. Requests arriving mid-pulse are queued and replayed.
module pulse_stretcher import stopwatch_pkg::*; #(
    parameter int unsigned HIGH_CYCLES = STRETCH_HIGH_DEFAULT,
    parameter int unsigned LOW_CYCLES  = STRETCH_LOW_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = STRETCH_DEPTH_DEFAULT
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_pulse,
    input  logic                               i_clr_ovf,
    output logic                               o_level,
    output logic                               o_busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_pending,
    output logic                               o_overflow
);

    localparam int unsigned CntMax = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int unsigned CntW   = ($clog2(CntMax) < 1) ? 1 : $clog2(CntMax);
    localparam int unsigned PendW  = $clog2(QUEUE_DEPTH + 1);

    localparam logic [CntW-1:0] HighLoad = CntW'(HIGH_CYCLES - 1);
    localparam logic [CntW-1:0] LowLoad  = CntW'(LOW_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
    logic            pend_inc, pend_dec;
    logic            pend_full, pend_empty;
    logic            drop;

    sat_updown_cnt #(
        .MAX_VAL (QUEUE_DEPTH),
        .WIDTH   (PendW)
    ) u_pending (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .inc_i     (pend_inc),
        .dec_i     (pend_dec),
        .count_o   (o_pending),
        .at_max_o  (pend_full),
        .at_zero_o (pend_empty)
    );

    // FSM, timer and queue control; outputs are derived from the next state so
    // they register on the same edge as the transition
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_inc = 1'b0;
        pend_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_pulse) begin
                    state_d = HIGH;
                    cnt_d   = HighLoad;
                end
            end
            HIGH: begin
                pend_inc = i_pulse;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = LowLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            GAP: begin
                pend_inc = i_pulse;
                if (cnt_q == '0) begin
                    if (!pend_empty || i_pulse) begin
                        state_d = HIGH;
                        cnt_d   = HighLoad;
                        if (!pend_empty) begin
                            pend_dec = 1'b1;
                        end else begin
                            // Empty queue: the new request is served directly
                            pend_inc = 1'b0;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A request is lost only when the queue is full and nothing leaves it
        drop    = pend_inc && !pend_dec && pend_full;
        level_d = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
        ovf_d   = drop ? 1'b1 : (i_clr_ovf ? 1'b0 : ovf_q);
    end

    // State and output registers; reset overrides everything, even mid-pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_level    = level_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus randomized traffic, all
// compared against a timeline model of the stretcher's behaviour.
module tb_pulse_stretcher;

    localparam int unsigned H  = 3;
    localparam int unsigned L  = 2;
    localparam int unsigned Q  = 2;
    localparam int          PW = $clog2(Q + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulse = 1'b0;
    logic          clr = 1'b0;
    logic          level;
    logic          busy;
    logic [PW-1:0] pending;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: a pulse is described by its start edge; it is high for
    // H edges and the slot ends H+L edges after the start.
    int e;
    bit m_active;
    int m_start;
    int m_pend;
    bit m_ovf;

    pulse_stretcher #(
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .QUEUE_DEPTH (Q)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pulse    (pulse),
        .i_clr_ovf  (clr),
        .o_level    (level),
        .o_busy     (busy),
        .o_pending  (pending),
        .o_overflow (ovf)
    );

    always #10 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    task automatic model_update(input logic r, input logic p, input logic c);
        bit set;
        set = 0;
        e++;
        if (!r) begin
            m_active = 0;
            m_pend   = 0;
            m_ovf    = 0;
        end else begin
            if (!m_active) begin
                if (p) begin
                    m_active = 1;
                    m_start  = e;
                end
            end else if (e == m_start + int'(H + L)) begin
                if (m_pend > 0) begin
                    m_start = e;
                    if (!p) m_pend--;
                end else if (p) begin
                    m_start = e;
                end else begin
                    m_active = 0;
                end
            end else if (p) begin
                if (m_pend < int'(Q)) m_pend++;
                else set = 1;
            end
            if (set) m_ovf = 1;
            else if (c) m_ovf = 0;
        end
    endtask

    function automatic logic [PW+2:0] exp_vec();
        logic lvl;
        lvl = m_active && ((e - m_start) < int'(H));
        return {lvl, m_active, PW'(m_pend), m_ovf};
    endfunction

    function automatic logic [PW+2:0] dut_vec();
        return {level, busy, pending, ovf};
    endfunction

    // Drive inputs on the falling edge, advance the model at the rising edge,
    // and leave time 1 ns past the edge for sampling
    task automatic drive_edge(input logic r, input logic p, input logic c);
        @(negedge clk);
        rst_n = r;
        pulse = p;
        clr   = c;
        @(posedge clk);
        model_update(r, p, c);
        #1;
    endtask

    // Two reset edges (0 and 1); the scenario proper starts at edge 2
    task automatic begin_scenario();
        e        = -1;
        m_active = 0;
        m_start  = 0;
        m_pend   = 0;
        m_ovf    = 0;
        drive_edge(1'b0, 1'b0, 1'b0);
        drive_edge(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        begin_scenario();
        checks++;
        if (dut_vec() !== '0)
            $display("FAIL reset_idle: got %b, expected %b", dut_vec(), {(PW+3){1'b0}});
        if (dut_vec() !== '0) errors++;
        for (int k = 2; k <= 5; k++) drive_edge(1'b1, 1'b1, 1'b0);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup_ovf: got %b, expected 1", ovf);
        end
        drive_edge(1'b0, 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_wins: got %b, expected all zero", dut_vec());
        end
        drive_edge(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %b, expected %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        int nh;
        logic prev;
        nh = 0;
        prev = 1'b0;
        begin_scenario();
        for (int k = 2; k <= 20; k++) begin
            drive_edge(1'b1, k == 5, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single e=%0d: got %b, expected %b", e, dut_vec(), exp_vec());
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (level !== (k == 7)) begin
                    errors++;
                    $display("FAIL single_edge e=%0d: level got %b, expected %b", e, level, k == 7);
                end
            end
            if (k == 10) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_drop: got %b, expected 0", busy);
                end
            end
            if (level && !prev) nh++;
            prev = level;
        end
        checks++;
        if (nh !== 1) begin
            errors++;
            $display("FAIL single_count: got %0d highs, expected 1", nh);
        end
    endtask

    task automatic test_queued();
        int nh;
        logic prev;
        nh = 0;
        prev = 1'b0;
        begin_scenario();
        for (int k = 2; k <= 25; k++) begin
            drive_edge(1'b1, k == 5 || k == 6, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL queued e=%0d: got %b, expected %b", e, dut_vec(), exp_vec());
            end
            if (k == 6 || k == 10) begin
                checks++;
                if (pending !== PW'(k == 6)) begin
                    errors++;
                    $display("FAIL queued_pending e=%0d: got %0d, expected %0d", e, pending, k == 6);
                end
            end
            if (level && !prev) nh++;
            prev = level;
        end
        checks++;
        if (nh !== 2) begin
            errors++;
            $display("FAIL queued_count: got %0d highs, expected 2", nh);
        end
    endtask

    task automatic test_overflow();
        int nh;
        logic prev;
        nh = 0;
        prev = 1'b0;
        begin_scenario();
        for (int k = 2; k <= 32; k++) begin
            drive_edge(1'b1, k >= 5 && k <= 8 && k != 0, k == 30);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow e=%0d: got %b, expected %b", e, dut_vec(), exp_vec());
            end
            if (k == 7 || k == 8 || k == 29 || k == 30) begin
                checks++;
                if (ovf !== (k == 8 || k == 29)) begin
                    errors++;
                    $display("FAIL overflow_flag e=%0d: got %b, expected %b", e, ovf,
                             k == 8 || k == 29);
                end
            end
            if (k == 8) begin
                checks++;
                if (pending !== PW'(Q)) begin
                    errors++;
                    $display("FAIL overflow_sat: got %0d, expected %0d", pending, Q);
                end
            end
            if (level && !prev) nh++;
            prev = level;
        end
        checks++;
        if (nh !== 3) begin
            errors++;
            $display("FAIL overflow_count: got %0d highs, expected 3", nh);
        end
    endtask

    task automatic test_last_gap();
        int nh;
        int max_pend;
        logic prev;
        nh = 0;
        max_pend = 0;
        prev = 1'b0;
        begin_scenario();
        // Edge 10 is where the gap of the pulse started at 5 terminates
        for (int k = 2; k <= 22; k++) begin
            drive_edge(1'b1, k == 5 || k == 10, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL last_gap e=%0d: got %b, expected %b", e, dut_vec(), exp_vec());
            end
            if (k >= 9 && k <= 13) begin
                checks++;
                if (level !== (k >= 10 && k <= 12)) begin
                    errors++;
                    $display("FAIL last_gap_level e=%0d: got %b, expected %b", e, level,
                             k >= 10 && k <= 12);
                end
            end
            if (int'(pending) > max_pend) max_pend = int'(pending);
            if (level && !prev) nh++;
            prev = level;
        end
        checks++;
        if (max_pend !== 0 || nh !== 2) begin
            errors++;
            $display("FAIL last_gap_summary: got pend_max %0d highs %0d, expected 0 and 2",
                     max_pend, nh);
        end
    endtask

    task automatic test_reset_mid_high();
        int nh;
        logic prev;
        nh = 0;
        prev = 1'b0;
        begin_scenario();
        for (int k = 2; k <= 25; k++) begin
            drive_edge(k != 6, k == 4 || k == 5, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid e=%0d: got %b, expected %b", e, dut_vec(), exp_vec());
            end
            if (k == 5) begin
                checks++;
                if ({level, pending} !== {1'b1, PW'(1)}) begin
                    errors++;
                    $display("FAIL reset_mid_setup: got lvl %b pend %0d, expected 1 and 1",
                             level, pending);
                end
            end
            if (k == 6) begin
                checks++;
                if (dut_vec() !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_clear: got %b, expected all zero", dut_vec());
                end
            end
            if (k > 6 && level && !prev) nh++;
            prev = level;
        end
        checks++;
        if (nh !== 0) begin
            errors++;
            $display("FAIL reset_mid_after: got %0d highs, expected 0", nh);
        end
    endtask

    task automatic test_held();
        int nh;
        logic prev;
        nh = 0;
        prev = 1'b0;
        begin_scenario();
        // Held 5..8, then one more request at 9 colliding with a clear
        for (int k = 2; k <= 25; k++) begin
            drive_edge(1'b1, k >= 5 && k <= 9, k == 9);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL held e=%0d: got %b, expected %b", e, dut_vec(), exp_vec());
            end
            if (k == 8 || k == 9) begin
                checks++;
                if (ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL held_ovf e=%0d: got %b, expected 1", e, ovf);
                end
            end
            if (level && !prev) nh++;
            prev = level;
        end
        checks++;
        if (nh !== 3) begin
            errors++;
            $display("FAIL held_count: got %0d highs, expected 3", nh);
        end
    endtask

    task automatic test_random();
        int dens;
        logic r, p, c;
        begin_scenario();
        for (int k = 2; k < 2400; k++) begin
            dens = (((k / 200) % 3) == 0) ? 10 : ((((k / 200) % 3) == 1) ? 40 : 85);
            r = ($urandom_range(0, 149) != 0);
            p = ($urandom_range(0, 99) < dens);
            c = ($urandom_range(0, 99) < 4);
            drive_edge(r, p, c);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random e=%0d: got %b, expected %b", e, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queued();
        test_overflow();
        test_last_gap();
        test_reset_mid_high();
        test_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
